// File: rtl/baggage_drop_sequencer.sv
// baggage_drop_sequencer: qualifies averaged height samples, latches a stable height, then drops or rejects the bag
//
// Takes the averaged height stream and waits until STABLE_CNT consecutive valid samples
// stay within TOL of a reference. It then latches that reference and compares it against
// max_height_i for one cycle. A bag within the limit is armed and dropped with a
// DROP_CYCLES-long pulse once drop_en_i is high. A bag over the limit is flagged with
// reject_o until the belt reports empty (height 0).
//
// Ports:
//   clk               in   1  system clock, rising edge
//   rst               in   1  synchronous active-high reset
//   height_i          in   8  averaged height from sensor stage
//   sample_valid_i    in   1  height_i is a new sample this cycle
//   drop_en_i         in   1  permission to drop (level-sensitive in ARMED)
//   max_height_i      in   8  acceptance limit, sampled in DECIDE only
//   drop_ready_o      out  1  high while idle
//   height_latched_o  out  8  accepted stable height
//   drop_activated_o  out  1  actuator pulse, DROP_CYCLES long
//   reject_o          out  1  bag over limit, held until bag removed
//
// Optional feature macro SEQ_ABORT_EN: while ARMED, a zero sample returns to IDLE and a
// sample that drifts beyond TOL from the latched height restarts qualification. Both of
// these take priority over drop_en_i.
module baggage_drop_sequencer #(
    parameter int STABLE_CNT  = 4,
    parameter int TOL         = 1,
    parameter int DROP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] height_i,
    input  logic       sample_valid_i,
    input  logic       drop_en_i,
    input  logic [7:0] max_height_i,
    output logic       drop_ready_o,
    output logic [7:0] height_latched_o,
    output logic       drop_activated_o,
    output logic       reject_o
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] STABILIZE = 3'd1;
    localparam logic [2:0] DECIDE    = 3'd2;
    localparam logic [2:0] ARMED     = 3'd3;
    localparam logic [2:0] DROP      = 3'd4;
    localparam logic [2:0] COOLDOWN  = 3'd5;
    localparam logic [2:0] REJECT    = 3'd6;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(DROP_CYCLES + 1);

    logic [2:0]    state_q, state_d;
    logic [7:0]    ref_q, ref_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    latched_q, latched_d;
    logic          drop_q, reject_q;
    logic          zero_smp, in_tol;

    // Unsigned distance without wrap-around: 0 vs 255 gives 255.
    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    endfunction

    assign zero_smp = sample_valid_i && (height_i == 8'd0);
    assign in_tol   = abs_diff(height_i, ref_q) <= 9'(TOL);

`ifdef SEQ_ABORT_EN
    logic drift;
    assign drift = abs_diff(height_i, latched_q) > 9'(TOL);
`endif

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        latched_d = latched_q;
        case (state_q)
            IDLE: begin
                if (sample_valid_i && height_i != 8'd0) begin
                    state_d = STABILIZE;
                    ref_d   = height_i;
                    cnt_d   = CW'(1);
                end
            end
            STABILIZE: begin
                if (zero_smp) begin
                    state_d = IDLE;
                end else if (sample_valid_i && in_tol) begin
                    cnt_d = cnt_q + CW'(1);
                    // The reference, not the last sample, becomes the accepted height.
                    if (cnt_q + CW'(1) == CW'(STABLE_CNT)) begin
                        latched_d = ref_q;
                        state_d   = DECIDE;
                    end
                end else if (sample_valid_i) begin
                    ref_d = height_i;
                    cnt_d = CW'(1);
                end
            end
            DECIDE: state_d = (latched_q > max_height_i) ? REJECT : ARMED;
            ARMED: begin
`ifdef SEQ_ABORT_EN
                if (zero_smp) begin
                    state_d = IDLE;
                end else if (sample_valid_i && drift) begin
                    state_d = STABILIZE;
                    ref_d   = height_i;
                    cnt_d   = CW'(1);
                end else if (drop_en_i) begin
                    state_d = DROP;
                    timer_d = '0;
                end
`else
                if (drop_en_i) begin
                    state_d = DROP;
                    timer_d = '0;
                end
`endif
            end
            DROP: begin
                if (timer_q == TW'(DROP_CYCLES - 1)) state_d = COOLDOWN;
                else timer_d = timer_q + TW'(1);
            end
            COOLDOWN, REJECT: state_d = zero_smp ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            latched_q <= '0;
            drop_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            latched_q <= latched_d;
            // Outputs are registered copies of the next-state decode, so they track DROP/REJECT exactly.
            drop_q    <= (state_d == DROP);
            reject_q  <= (state_d == REJECT);
        end
    end

    assign drop_ready_o     = (state_q == IDLE);
    assign height_latched_o = latched_q;
    assign drop_activated_o = drop_q;
    assign reject_o         = reject_q;
endmodule

// File: tb/tb_baggage_drop_sequencer.sv
// tb_baggage_drop_sequencer: directed self-checking bench for baggage_drop_sequencer
module tb_baggage_drop_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] height;
    logic       sample_valid;
    logic       drop_en;
    logic [7:0] max_height;
    logic       drop_ready;
    logic [7:0] height_latched;
    logic       drop_activated;
    logic       reject;
    int         total = 0;
    int         bad = 0;

    baggage_drop_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .height_i         (height),
        .sample_valid_i   (sample_valid),
        .drop_en_i        (drop_en),
        .max_height_i     (max_height),
        .drop_ready_o     (drop_ready),
        .height_latched_o (height_latched),
        .drop_activated_o (drop_activated),
        .reject_o         (reject)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [7:0] h);
        sample_valid = 1'b1;
        height = h;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hi_cnt;
        int first_hi;
        int drop_seen;
        rst = 1'b1;
        height = 8'd0;
        sample_valid = 1'b0;
        drop_en = 1'b0;
        max_height = 8'd100;
        step();
        step();
        chk("rst_ready", drop_ready, 1);
        chk("rst_drop", drop_activated, 0);
        chk("rst_reject", reject, 0);
        chk("rst_latched", height_latched, 0);
        rst = 1'b0;
        smp(8'd0);
        chk("idle_zero_ignored", drop_ready, 1);
        drop_en = 1'b1;
        smp(8'd50);
        chk("stab_ready", drop_ready, 0);
        smp(8'd51);
        smp(8'd50);
        smp(8'd50);
        chk("t1_latched", height_latched, 50);
        chk("t1_decide_nodrop", drop_activated, 0);
        hi_cnt = 0;
        first_hi = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (drop_activated) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        chk("t1_pulse_len", hi_cnt, 16);
        chk("t1_pulse_start", first_hi, 2);
        chk("t1_cooldown_ready", drop_ready, 0);
        chk("t1_latched_hold", height_latched, 50);
        drop_en = 1'b0;
        smp(8'd0);
        chk("t1_back_idle", drop_ready, 1);
        smp(8'd50);
        smp(8'd60);
        step();
        step();
        smp(8'd60);
        smp(8'd60);
        chk("t2_not_yet", height_latched, 50);
        chk("t2_still_stab", drop_ready, 0);
        smp(8'd60);
        chk("t2_latched", height_latched, 60);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t2_rst_latched", height_latched, 0);
        drop_en = 1'b1;
        repeat (4) smp(8'd120);
        chk("t3_latched", height_latched, 120);
        chk("t3_decide_noreject", reject, 0);
        step();
        chk("t3_reject", reject, 1);
        drop_seen = 0;
        repeat (5) begin
            step();
            if (drop_activated) drop_seen = 1;
        end
        chk("t3_no_drop", drop_seen, 0);
        chk("t3_reject_held", reject, 1);
        smp(8'd0);
        chk("t3_reject_clr", reject, 0);
        chk("t3_idle", drop_ready, 1);
        drop_en = 1'b0;
        repeat (4) smp(8'd100);
        chk("t4_latched", height_latched, 100);
        drop_seen = 0;
        repeat (20) begin
            step();
            if (drop_activated || reject || drop_ready) drop_seen = 1;
        end
        chk("t4_armed_hold", drop_seen, 0);
`ifndef SEQ_ABORT_EN
        smp(8'd0);
        chk("t4_armed_ignores_zero", drop_ready, 0);
`endif
        drop_en = 1'b1;
        step();
        chk("t5_drop_on", drop_activated, 1);
        repeat (5) step();
        chk("t5_drop_timer5", drop_activated, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drop_en = 1'b0;
        chk("t5_rst_drop", drop_activated, 0);
        chk("t5_rst_idle", drop_ready, 1);
`ifdef SEQ_ABORT_EN
        repeat (4) smp(8'd50);
        step();
        drop_en = 1'b1;
        smp(8'd0);
        chk("t6_abort_idle", drop_ready, 1);
        chk("t6_abort_nodrop", drop_activated, 0);
        drop_en = 1'b0;
        step();
        chk("t6_abort_still_nodrop", drop_activated, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
